// File: rtl/ltpi_dc_responder.sv
// LTPI management data channel responder: executes one decoded request frame as a
// local bus access and returns a tagged response. Optional parity: LTPI_DC_RESP_PARITY_EN.
module ltpi_dc_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_cmd,
  input  logic [7:0]          req_tag,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
`ifdef LTPI_DC_RESP_PARITY_EN
  input  logic                req_parity,
  output logic                resp_parity,
`endif
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [1:0]          resp_cmd,
  output logic [7:0]          resp_tag,
  output logic [1:0]          resp_status,
  output logic [DATA_W-1:0]   resp_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUSERR  = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_UNSUP   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t              state_reg, state_next;
  logic                req_ready_reg;
  logic [1:0]          cmd_reg;
  logic [7:0]          tag_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [BE_W-1:0]     be_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [1:0]          status_reg, status_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                resp_load;
  logic                accept;
  logic                par_err;
  logic                timeout_hit;

  assign accept      = (state_reg == S_IDLE) & req_valid & req_ready_reg;
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

`ifdef LTPI_DC_RESP_PARITY_EN
  logic resp_parity_reg;
  logic resp_parity_next;

  assign par_err = req_parity ^ (^{req_cmd, req_tag, req_addr, req_wdata, req_be});

  // In IDLE the response is built straight from the request fields, not the holding registers.
  assign resp_parity_next = ^{(state_reg == S_IDLE) ? req_cmd : cmd_reg,
                              (state_reg == S_IDLE) ? req_tag : tag_reg,
                              status_next, rdata_next};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_parity_reg <= 1'b0;
    end else if (resp_load) begin
      resp_parity_reg <= resp_parity_next;
    end
  end

  assign resp_parity = resp_parity_reg;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    status_next = status_reg;
    rdata_next  = rdata_reg;
    resp_load   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (req_cmd[1] || par_err) begin
            state_next  = S_RESP;
            status_next = ST_UNSUP;
            rdata_next  = '0;
            resp_load   = 1'b1;
          end else begin
            state_next = S_BUS;
          end
        end
      end
      S_BUS: begin
        // An ack arriving on the timeout cycle still completes the access.
        if (bus_ack) begin
          state_next  = S_RESP;
          status_next = bus_err ? ST_BUSERR : ST_OK;
          rdata_next  = (!bus_err && !cmd_reg[0]) ? bus_rdata : '0;
          resp_load   = 1'b1;
        end else if (timeout_hit) begin
          state_next  = S_RESP;
          status_next = ST_TIMEOUT;
          rdata_next  = '0;
          resp_load   = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      req_ready_reg <= 1'b0;
      cmd_reg       <= '0;
      tag_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      cnt_reg       <= '0;
      status_reg    <= '0;
      rdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= (state_next == S_IDLE);
      if (accept) begin
        cmd_reg   <= req_cmd;
        tag_reg   <= req_tag;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        be_reg    <= req_be;
      end
      // Counter reads zero on the first BUS cycle of every access.
      if (state_reg == S_BUS && state_next == S_BUS) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else begin
        cnt_reg <= '0;
      end
      if (resp_load) begin
        status_reg <= status_next;
        rdata_reg  <= rdata_next;
      end
    end
  end

  assign req_ready   = req_ready_reg;
  assign bus_req     = (state_reg == S_BUS);
  assign bus_we      = (state_reg == S_BUS) & cmd_reg[0];
  assign bus_addr    = addr_reg;
  assign bus_wdata   = wdata_reg;
  assign bus_be      = be_reg;
  assign resp_valid  = (state_reg == S_RESP);
  assign resp_cmd    = cmd_reg;
  assign resp_tag    = tag_reg;
  assign resp_status = status_reg;
  assign resp_rdata  = rdata_reg;

endmodule

// File: tb/tb_ltpi_dc_responder.sv
// Scoreboard bench for ltpi_dc_responder (default build, TIMEOUT_CYC=16).
module tb_ltpi_dc_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_cmd;
  logic [7:0]  req_tag;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_cmd;
  logic [7:0]  resp_tag;
  logic [1:0]  resp_status;
  logic [31:0] resp_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [7:0]  tag;
    logic [1:0]  status;
    logic [31:0] rdata;
  } resp_t;

  resp_t exp_q[$];

  ltpi_dc_responder #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_tag(req_tag),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_cmd(resp_cmd),
    .resp_tag(resp_tag), .resp_status(resp_status), .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  // Response monitor: every handshake must match the oldest expected response.
  always @(negedge clk) begin
    resp_t act;
    resp_t e;
    if (reset_n && resp_valid && resp_ready) begin
      act = {resp_cmd, resp_tag, resp_status, resp_rdata};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected got=%h expected=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL resp_match got=%h expected=%h", act, e);
        end else begin
          $display("resp cmd=%0d tag=%h status=%0d rdata=%h ok", resp_cmd, resp_tag, resp_status, resp_rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns in the first cycle after the accepting edge.
  task automatic do_accept(input logic [1:0] cmd, input logic [7:0] tag,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    req_valid = 1'b1;
    req_cmd = cmd; req_tag = tag; req_addr = addr; req_wdata = wdata; req_be = be;
    for (int i = 0; i < 60 && !req_ready; i++) tick();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait req_ready=%b required=1", req_ready);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready, bus_req, bus_we, resp_valid, resp_status, resp_tag, resp_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b bus_req=%b resp_valid=%b tag=%h required all 0",
               req_ready, bus_req, resp_valid, resp_tag);
    end
    tick(); tick();
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_held got=%b required=0", req_ready); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_release got=%b required=0", req_ready); end
    tick();
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b required=1", req_ready); end
    $display("reset done");
  endtask

  task automatic test_read_zero_wait();
    do_accept(2'd0, 8'h5A, 32'h0000_0010, 32'h0, 4'hF);
    checks++;
    if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h10) begin
      failures++;
      $display("FAIL read_bus req=%b we=%b addr=%h required 1/0/00000010", bus_req, bus_we, bus_addr);
    end
    exp_q.push_back({2'd0, 8'h5A, 2'b00, 32'hDEAD_BEEF});
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    checks++;
    if (resp_valid !== 1'b1 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL read_latency resp_valid=%b bus_req=%b required 1/0", resp_valid, bus_req);
    end
    drain("read");
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_return_idle ready=%b resp_valid=%b required 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_write_err();
    int bad = 0;
    do_accept(2'd1, 8'h21, 32'h20, 32'h1234_5678, 4'hF);
    exp_q.push_back({2'd1, 8'h21, 2'b01, 32'h0});
    for (int k = 0; k < 5; k++) begin
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h20 ||
          bus_wdata !== 32'h1234_5678 || bus_be !== 4'hF) bad++;
      if (k == 4) begin bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hFFFF_FFFF; end
      tick();
    end
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL write_bus_stable bad_cycles=%0d required=0", bad); end
    checks++;
    if (bus_req !== 1'b0 || resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL write_exit bus_req=%b resp_valid=%b required 0/1", bus_req, resp_valid);
    end
    drain("write");
  endtask

  task automatic test_timeout();
    int n = 0;
    do_accept(2'd0, 8'h33, 32'h40, 32'h0, 4'hF);
    exp_q.push_back({2'd0, 8'h33, 2'b10, 32'h0});
    while (bus_req === 1'b1 && n < 100) begin n++; tick(); end
    checks++;
    if (n != 16) begin failures++; $display("FAIL timeout_len bus_req_cycles=%0d required=16", n); end
    resp_ready = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    checks++;
    if (resp_status !== 2'b10 || resp_rdata !== 32'h0 || bus_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout_late_ack status=%b rdata=%h bus_req=%b required 10/0/0", resp_status, resp_rdata, bus_req);
    end
    resp_ready = 1'b1;
    drain("timeout");
  endtask

  task automatic test_unsupported();
    do_accept(2'd2, 8'h11, 32'h80, 32'h0, 4'hF);
    exp_q.push_back({2'd2, 8'h11, 2'b11, 32'h0});
    checks++;
    if (bus_req !== 1'b0 || resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL unsup_path bus_req=%b resp_valid=%b required 0/1", bus_req, resp_valid);
    end
    drain("unsup");
    checks++;
    if (bus_req !== 1'b0) begin failures++; $display("FAIL unsup_bus got=%b required=0", bus_req); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    resp_ready = 1'b0;
    do_accept(2'd0, 8'h77, 32'h50, 32'h0, 4'hF);
    exp_q.push_back({2'd0, 8'h77, 2'b00, 32'hCAFE_F00D});
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    req_valid = 1'b1; req_cmd = 2'd0; req_tag = 8'h78; req_addr = 32'h54; req_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (resp_valid !== 1'b1 || resp_tag !== 8'h77 || resp_rdata !== 32'hCAFE_F00D ||
          resp_status !== 2'b00 || req_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_stable bad_cycles=%0d required=0", bad); end
    resp_ready = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle ready=%b resp_valid=%b required 1/0", req_ready, resp_valid);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h54) begin
      failures++;
      $display("FAIL bp_second bus_req=%b addr=%h required 1/00000054", bus_req, bus_addr);
    end
    exp_q.push_back({2'd0, 8'h78, 2'b00, 32'h600D_F00D});
    bus_ack = 1'b1; bus_rdata = 32'h600D_F00D;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    drain("bp");
  endtask

  task automatic test_reset_mid();
    do_accept(2'd0, 8'h99, 32'h90, 32'h0, 4'hF);
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async bus_req=%b resp_valid=%b ready=%b required 0/0/0", bus_req, resp_valid, req_ready);
    end
    bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    reset_n = 1'b1;
    tick(); tick();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_recover resp_valid=%b ready=%b required 0/1", resp_valid, req_ready);
    end
    do_accept(2'd1, 8'hA0, 32'hA0, 32'h0BAD_CAFE, 4'h3);
    exp_q.push_back({2'd1, 8'hA0, 2'b00, 32'h0});
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    drain("rst_mid");
  endtask

  task automatic test_back_to_back();
    logic [1:0] cmds [4] = '{2'd0, 2'd1, 2'd3, 2'd0};
    logic [3:0] bes  [4] = '{4'hF, 4'h0, 4'hF, 4'h3};
    logic       errs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         dly  [4] = '{0, 2, 0, 1};
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] rd;
      logic [1:0]  st;
      rd = 32'hA500_0000 | 32'(i);
      st = cmds[i][1] ? 2'b11 : (errs[i] ? 2'b01 : 2'b00);
      do_accept(cmds[i], 8'hB0 + 8'(i), 32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i), bes[i]);
      exp_q.push_back({cmds[i], 8'hB0 + 8'(i), st,
                       (cmds[i] == 2'd0 && !errs[i]) ? rd : 32'h0});
      if (!cmds[i][1]) begin
        if (bus_req !== 1'b1 || bus_be !== bes[i] || bus_we !== cmds[i][0]) bad++;
        for (int d = 0; d < dly[i]; d++) tick();
        bus_ack = 1'b1; bus_err = errs[i]; bus_rdata = rd;
        tick();
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
      end else if (bus_req !== 1'b0) begin
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL b2b_bus bad=%0d required=0", bad); end
    drain("b2b");
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_tag = '0; req_addr = '0;
    req_wdata = '0; req_be = '0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    resp_ready = 1'b1;
    test_reset();
    test_read_zero_wait();
    test_write_err();
    test_timeout();
    test_unsupported();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL final_queue pending=%0d required=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
